// File: rtl/fcvt_pkg.sv
// ----------------------------------------------------------------------------
// fcvt_pkg
// Shared types and constants for the int32 -> FP32 conversion scheduler.
//   rm_e      : rounding mode encoding (RISC-V style, DYN selects frm)
//   s1_t      : operand-stage payload (operand, resolved rm, illegal mark, id)
//   result_t  : output-stage payload (FP32 result, flags, id)
//   resolve_rm: maps a requested rm plus frm to {illegal, effective rm}
// ----------------------------------------------------------------------------
package fcvt_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } rm_e;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam int unsigned FP32_BIAS = 127;

    // Widest requester tag (NREQ <= 8); narrower configurations use the low bits.
    localparam int unsigned IDW_MAX = 3;

    typedef struct packed {
        logic [31:0]        opnd;
        rm_e                rm;
        logic               illegal;
        logic [IDW_MAX-1:0] id;
    } s1_t;

    typedef struct packed {
        logic [31:0]        num;
        logic               nx;
        logic               nv;
        logic [IDW_MAX-1:0] id;
    } result_t;

    // Returns {illegal, effective_rm}. A dynamic request takes frm; any
    // encoding outside RNE..RMM after that substitution is illegal, which also
    // covers frm itself holding a reserved value.
    function automatic logic [3:0] resolve_rm(logic [2:0] req_rm, logic [2:0] frm);
        logic [2:0] eff;
        logic       bad;
        eff = (req_rm == DYN) ? frm : req_rm;
        bad = (eff > RMM);
        return {bad, bad ? RNE : eff};
    endfunction

endpackage

// File: rtl/i2f_round.sv
// ----------------------------------------------------------------------------
// i2f_round
// Purely combinational signed int32 -> FP32 conversion with rounding.
//   op_i  : signed 32-bit integer operand
//   rm_i  : rounding mode (RNE/RTZ/RDN/RUP/RMM; other values never round up)
//   num_o : FP32 result
//   nx_o  : inexact flag (guard | sticky)
// ----------------------------------------------------------------------------
module i2f_round
    import fcvt_pkg::*;
(
    input  logic [31:0] op_i,
    input  logic [2:0]  rm_i,
    output logic [31:0] num_o,
    output logic        nx_o
);

    logic        sign;
    logic [31:0] mag;
    logic [4:0]  lead_pos;
    logic [31:0] norm;
    logic [23:0] mant;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [24:0] sum;
    logic [7:0]  expo;
    logic [22:0] frac;

    always_comb begin
        sign = op_i[31];
        // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
        mag  = sign ? (~op_i + 32'd1) : op_i;

        lead_pos = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) begin
                lead_pos = 5'(i);
            end
        end

        // Left-justify so the leading one sits at bit 31; the 24 kept bits,
        // guard and sticky then fall at fixed positions for every magnitude.
        norm   = mag << (5'd31 - lead_pos);
        mant   = norm[31:8];
        guard  = norm[7];
        sticky = |norm[6:0];

        round_up = 1'b0;
        case (rm_i)
            RNE:     round_up = guard & (sticky | mant[0]);
            RTZ:     round_up = 1'b0;
            RDN:     round_up = sign & (guard | sticky);
            RUP:     round_up = ~sign & (guard | sticky);
            RMM:     round_up = guard;
            default: round_up = 1'b0;
        endcase

        sum  = {1'b0, mant} + {24'd0, round_up};
        // Carry out of the mantissa bumps the exponent; the fraction is then
        // all zeros. The exponent tops out at 127+31+1, so no overflow path.
        expo = 8'(FP32_BIAS) + {3'd0, lead_pos} + {7'd0, sum[24]};
        frac = sum[24] ? 23'd0 : sum[22:0];

        if (mag == 32'd0) begin
            num_o = 32'd0;
            nx_o  = 1'b0;
        end else begin
            num_o = {sign, expo, frac};
            nx_o  = guard | sticky;
        end
    end

endmodule

// File: rtl/fcvt_sched.sv
// ----------------------------------------------------------------------------
// fcvt_sched
// Shares one int32 -> FP32 converter between NREQ requesters. Round-robin
// arbitration feeds a two-stage pipeline: S1 captures operand/rm/id, S2
// registers the converted, rounded result.
//   clk, rst_n           : clock, synchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (only the grantee is ready)
//   req_int, req_rm      : per-requester operand (32b) and rounding mode (3b)
//   frm                  : dynamic rounding mode for req_rm = 3'b111
//   out_valid/out_ready  : result handshake
//   out_num/out_id       : FP32 result and requester tag
//   out_nx/out_nv        : inexact and illegal-rounding-mode flags
// ----------------------------------------------------------------------------
module fcvt_sched
    import fcvt_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_int,
    input  logic [NREQ*3-1:0] req_rm,
    input  logic [2:0]        frm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_num,
    output logic [IDW-1:0]    out_id,
    output logic              out_nx,
    output logic              out_nv
);

    logic           s1_valid_q, s1_valid_d;
    s1_t            s1_q, s1_d;
    logic           s2_valid_q, s2_valid_d;
    result_t        s2_q, s2_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           s2_can_accept;
    logic           s1_can_load;
    logic           grant_vld;
    logic [IDW-1:0] grant_idx;
    logic           accept;
    logic [31:0]    sel_int;
    logic [2:0]     sel_rm;
    logic [3:0]     rm_res;
    logic [31:0]    conv_num;
    logic           conv_nx;
    result_t        conv_res;

    // Occupancy chain: S1 may load if empty or if its entry moves into S2.
    assign s2_can_accept = !s2_valid_q || out_ready;
    assign s1_can_load   = !s1_valid_q || s2_can_accept;

    // Round-robin search from the pointer. Walking k downward lets the
    // smallest offset win.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % int'(NREQ);
            if (req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && grant_vld && s1_can_load) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        int sel;
        sel     = int'(grant_idx);
        sel_int = req_int[sel*32 +: 32];
        sel_rm  = req_rm[sel*3 +: 3];
    end

    assign rm_res = resolve_rm(sel_rm, frm);

    i2f_round u_i2f_round (
        .op_i  (s1_q.opnd),
        .rm_i  (s1_q.rm),
        .num_o (conv_num),
        .nx_o  (conv_nx)
    );

    always_comb begin
        conv_res.id = s1_q.id;
        if (s1_q.illegal) begin
            conv_res.num = FP32_QNAN;
            conv_res.nx  = 1'b0;
            conv_res.nv  = 1'b1;
        end else begin
            conv_res.num = conv_num;
            conv_res.nx  = conv_nx;
            conv_res.nv  = 1'b0;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        ptr_d      = ptr_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;

        if (s1_can_load) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_d.opnd    = sel_int;
                s1_d.rm      = rm_e'(rm_res[2:0]);
                s1_d.illegal = rm_res[3];
                s1_d.id      = IDW_MAX'(grant_idx);
            end
        end

        if (accept) begin
            ptr_d = (int'(grant_idx) == int'(NREQ) - 1) ? '0 : grant_idx + IDW'(1);
        end

        if (s2_can_accept) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d = conv_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
            ptr_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_num   = s2_q.num;
    assign out_id    = s2_q.id[IDW-1:0];
    assign out_nx    = s2_q.nx;
    assign out_nv    = s2_q.nv;

    // Tag bits above IDW are always zero for narrow configurations.
    logic unused_id;
    assign unused_id = ^s2_q.id;

endmodule

// File: tb/tb_fcvt_sched.sv
module tb_fcvt_sched;

    localparam int NREQ = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_int;
    logic [NREQ*3-1:0]    req_rm;
    logic [2:0]           frm;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_num;
    logic [0:0]           out_id;
    logic                 out_nx;
    logic                 out_nv;

    always #5 clk = ~clk;

    fcvt_sched #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_int   (req_int),
        .req_rm    (req_rm),
        .frm       (frm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_num   (out_num),
        .out_id    (out_id),
        .out_nx    (out_nx),
        .out_nv    (out_nv)
    );

    typedef struct {
        logic [31:0] num;
        logic        nx;
        logic        nv;
        int          id;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          mptr     = 0;
    int          last_acc = -1;
    int          grants[$];
    bit          dir_en   = 1'b0;
    logic [31:0] dir_num;
    logic        dir_nx;
    logic        dir_nv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference conversion from the numeric value: split the magnitude into
    // a 24-bit quotient and a remainder, then round by comparing to one half.
    function automatic logic [32:0] ref_cvt(input logic [31:0] op, input logic [2:0] rm);
        longint v, mag, q, rem, half;
        int     p, sh;
        bit     s, up;
        logic [7:0] e;
        v   = longint'($signed(op));
        s   = (v < 0);
        mag = s ? -v : v;
        if (mag == 0) return 33'd0;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        if (p <= 23) begin
            q = mag << (23 - p); rem = 0; half = 1;
        end else begin
            sh = p - 23; q = mag >> sh; rem = mag - (q << sh); half = longint'(1) << (sh - 1);
        end
        case (rm)
            3'd0:    up = (rem > half) || (rem == half && q[0]);
            3'd1:    up = 1'b0;
            3'd2:    up = s && (rem != 0);
            3'd3:    up = !s && (rem != 0);
            3'd4:    up = (rem != 0) && (rem >= half);
            default: up = 1'b0;
        endcase
        q = q + longint'(up);
        e = 8'(127 + p);
        if (q == (longint'(1) << 24)) begin
            q = longint'(1) << 23;
            e = e + 8'd1;
        end
        return {rem != 0, s, e, q[22:0]};
    endfunction

    function automatic exp_t model(input logic [31:0] op, input logic [2:0] rm,
                                   input logic [2:0] f, input int id);
        exp_t       e;
        logic [2:0] eff;
        eff  = (rm == 3'b111) ? f : rm;
        e.id = id;
        if (eff > 3'd4) begin
            e.num = 32'h7FC0_0000; e.nx = 1'b0; e.nv = 1'b1;
        end else begin
            {e.nx, e.num} = ref_cvt(op, eff);
            e.nv = 1'b0;
        end
        return e;
    endfunction

    // One clock of stimulus: apply at negedge, then check req_ready against
    // the arbitration/capacity model and record any handshake.
    task automatic drive(input bit rst, input logic [NREQ-1:0] v,
                         input logic [31:0] i0, input logic [31:0] i1,
                         input logic [2:0] r0, input logic [2:0] r1,
                         input logic [2:0] f, input bit ordy);
        int              g;
        int              idx;
        logic [NREQ-1:0] exp_rdy;
        exp_t            e;
        @(negedge clk);
        rst_n     = !rst;
        req_valid = v;
        req_int   = {i1, i0};
        req_rm    = {r1, r0};
        frm       = f;
        out_ready = ordy;
        #2;
        last_acc = -1;
        if (!rst_n) begin
            chk("ready_in_reset", 32'(req_ready), 32'd0);
            sb.delete();
            mptr = 0;
        end else begin
            g = -1;
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx = (mptr + k) % NREQ;
                if (req_valid[idx]) g = idx;
            end
            exp_rdy = '0;
            // Two entries of storage; a full pipe frees a slot only if the
            // head is leaving this cycle.
            if (g >= 0 && (sb.size() < 2 || out_ready)) exp_rdy[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) last_acc = i;
            end
            if (last_acc >= 0) begin
                e = model(req_int[last_acc*32 +: 32], req_rm[last_acc*3 +: 3], frm, last_acc);
                if (dir_en) begin
                    e.num = dir_num; e.nx = dir_nx; e.nv = dir_nv;
                end
                sb.push_back(e);
                grants.push_back(last_acc);
                mptr = (last_acc + 1) % NREQ;
            end
        end
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, '0, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, ordy);
    endtask

    task automatic send(input logic [31:0] op, input logic [2:0] rm, input logic [2:0] f,
                        input logic [31:0] num, input logic nx, input logic nv);
        dir_en = 1'b1; dir_num = num; dir_nx = nx; dir_nv = nv;
        drive(1'b0, 2'b01, op, 32'd0, rm, 3'd0, f, 1'b1);
        dir_en = 1'b0;
        chk("send_accept", 32'(last_acc), 32'd0);
        repeat (3) idle(1'b1);
    endtask

    function automatic logic [31:0] rand_int();
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 40)) - 32'd20;
            2:       return 32'h8000_0000;
            3:       return (32'd1 << $urandom_range(0, 31)) | 32'($urandom_range(0, 3));
            default: return 32'h0100_0001 ^ 32'($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'd0);
        endcase
    endfunction

    // Monitor: whenever a result is presented it must match the head of the
    // scoreboard; it is popped only on the handshake, so a held result is
    // re-checked each stalled cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 32'd1, 32'd0);
                end else begin
                    e = sb[0];
                    chk("out_num", out_num, e.num);
                    chk("out_nx", 32'(out_nx), 32'(e.nx));
                    chk("out_nv", 32'(out_nv), 32'(e.nv));
                    chk("out_id", 32'(out_id), 32'(e.id));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int accepts;
        int b;
        rst_n = 1'b0; req_valid = '0; req_int = '0; req_rm = '0; frm = 3'd0; out_ready = 1'b1;

        repeat (2) drive(1'b1, 2'b11, 32'd5, 32'd6, 3'd0, 3'd0, 3'd0, 1'b1);
        idle(1'b1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_num", out_num, 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_out_nx", 32'(out_nx), 32'd0);
        chk("rst_out_nv", 32'(out_nv), 32'd0);

        // Latency: accept in cycle t, result visible in cycle t+2.
        dir_en = 1'b1; dir_num = 32'h3F80_0000; dir_nx = 1'b0; dir_nv = 1'b0;
        drive(1'b0, 2'b01, 32'd1, 32'd0, 3'd0, 3'd0, 3'd0, 1'b1);
        dir_en = 1'b0;
        chk("lat_accept", 32'(last_acc), 32'd0);
        idle(1'b1);
        chk("lat_t1_out_valid", 32'(out_valid), 32'd0);
        idle(1'b1);
        chk("lat_t2_out_valid", 32'(out_valid), 32'd1);
        idle(1'b1);

        send(32'hFFFF_FFFF, 3'b000, 3'd0, 32'hBF80_0000, 1'b0, 1'b0);
        send(32'h8000_0000, 3'b001, 3'd0, 32'hCF00_0000, 1'b0, 1'b0);
        send(32'h0000_0000, 3'b000, 3'd0, 32'h0000_0000, 1'b0, 1'b0);
        send(32'h0000_0000, 3'b011, 3'd0, 32'h0000_0000, 1'b0, 1'b0);
        send(32'h0100_0001, 3'b000, 3'd0, 32'h4B80_0000, 1'b1, 1'b0);
        send(32'h0100_0001, 3'b011, 3'd0, 32'h4B80_0001, 1'b1, 1'b0);
        send(32'h0100_0001, 3'b010, 3'd0, 32'h4B80_0000, 1'b1, 1'b0);
        send(32'hFEFF_FFFF, 3'b010, 3'd0, 32'hCB80_0001, 1'b1, 1'b0);
        send(32'h0100_0001, 3'b111, 3'b011, 32'h4B80_0001, 1'b1, 1'b0);
        send(32'h0100_0001, 3'b101, 3'd0, 32'h7FC0_0000, 1'b0, 1'b1);
        send(32'h0100_0001, 3'b110, 3'd0, 32'h7FC0_0000, 1'b0, 1'b1);

        // Backpressure: only two entries fit while out_ready is low.
        grants.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2'b01, 32'd100 + 32'(i), 32'd0, 3'd0, 3'd0, 3'd0, 1'b0);
        end
        chk("bp_accepts", 32'(grants.size()), 32'd2);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        repeat (4) idle(1'b1);
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // Reset with entries in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b11, $urandom, $urandom, 3'd0, 3'd1, 3'd0, 1'b1);
        end
        drive(1'b1, 2'b00, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 1'b1);
        idle(1'b1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);

        // Fair alternation from a freshly reset pointer.
        grants.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'b11, rand_int(), rand_int(), 3'($urandom_range(0, 4)),
                  3'($urandom_range(0, 4)), 3'd0, 1'b1);
        end
        chk("rr_count", 32'(grants.size()), 32'd8);
        for (int i = 0; i < grants.size(); i++) begin
            chk("rr_grant", 32'(grants[i]), 32'(i % 2));
        end
        repeat (3) idle(1'b1);

        for (int i = 0; i < 600; i++) begin
            drive(1'b0, 2'($urandom_range(0, 3)), rand_int(), rand_int(),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 5)), $urandom_range(0, 3) != 0);
        end

        b = 0;
        while (sb.size() > 0 && b < 20) begin
            idle(1'b1);
            b++;
        end
        chk("final_drain", 32'(sb.size()), 32'd0);

        accepts = n_checks;
        $display("End of test - %0d assertions evaluated, %0d failures", accepts, n_fail);
        $finish;
    end

endmodule
